// File: rtl/alu_ctrl.sv
// Handshaked controller that sequences one ALU operation per request (IDLE -> EXEC -> HOLD).
// Optional accumulator-as-op1 feature is compiled in with ALU_CTRL_ACC_EN.
module alu_ctrl #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned CWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_sel_i,
  input  logic [DWIDTH-1:0] req_op1_i,
  input  logic [DWIDTH-1:0] req_op2_i,
  input  logic              req_acc_i,
  output logic [1:0]        alu_sel_o,
  output logic [DWIDTH-1:0] alu_op1_o,
  output logic [DWIDTH-1:0] alu_op2_o,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic              alu_zero_i,
  input  logic              alu_neg_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_res_o,
  output logic              rsp_zero_o,
  output logic              rsp_neg_o,
  output logic [CWIDTH-1:0] op_count_o
);

  localparam logic [1:0] SelAdd = 2'b00;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        sel_q;
  logic [DWIDTH-1:0] op1_q, op2_q, op1_d;
  logic [DWIDTH-1:0] res_q;
  logic              zero_q, neg_q;
  logic [CWIDTH-1:0] cnt_q;
  logic              req_hs, rsp_hs;

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StHold);
  assign req_hs      = req_valid_i & req_ready_o;
  assign rsp_hs      = rsp_valid_o & rsp_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_hs) state_d = StExec;
      StExec:  state_d = StHold;
      StHold:  if (rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef ALU_CTRL_ACC_EN
  logic [DWIDTH-1:0] acc_q;

  // Accumulator tracks every ALU result, so a chained request sees the previous answer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (state_q == StExec) begin
      acc_q <= alu_res_i;
    end
  end

  assign op1_d = req_acc_i ? acc_q : req_op1_i;
`else
  logic unused_acc;
  assign unused_acc = req_acc_i;
  assign op1_d      = req_op1_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU-driving registers only change on accept, so they hold through EXEC, HOLD and IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q <= SelAdd;
      op1_q <= '0;
      op2_q <= '0;
    end else if (req_hs) begin
      sel_q <= req_sel_i;
      op1_q <= op1_d;
      op2_q <= req_op2_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (state_q == StExec) begin
      res_q  <= alu_res_i;
      zero_q <= alu_zero_i;
      neg_q  <= alu_neg_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (rsp_hs) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign alu_sel_o  = sel_q;
  assign alu_op1_o  = op1_q;
  assign alu_op2_o  = op2_q;
  assign rsp_res_o  = res_q;
  assign rsp_zero_o = zero_q;
  assign rsp_neg_o  = neg_q;
  assign op_count_o = cnt_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl with a behavioural ALU attached.
// Built with CWIDTH=4 so the counter wrap is reachable in 16 handshakes.
module tb_alu_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpOr  = 2'b10;
  localparam logic [1:0] OpAnd = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_acc;
  logic [1:0]    req_sel;
  logic [DW-1:0] req_op1, req_op2;
  logic [1:0]    alu_sel;
  logic [DW-1:0] alu_op1, alu_op2, alu_res;
  logic          alu_zero, alu_neg;
  logic          rsp_valid, rsp_ready, rsp_zero, rsp_neg;
  logic [DW-1:0] rsp_res;
  logic [CW-1:0] op_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_res = '0;
    case (alu_sel)
      OpAdd:   alu_res = alu_op1 + alu_op2;
      OpSub:   alu_res = alu_op1 - alu_op2;
      OpOr:    alu_res = alu_op1 | alu_op2;
      default: alu_res = alu_op1 & alu_op2;
    endcase
    alu_zero = (alu_res == '0);
    alu_neg  = alu_res[DW-1];
  end

  alu_ctrl #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_sel_i   (req_sel),
    .req_op1_i   (req_op1),
    .req_op2_i   (req_op2),
    .req_acc_i   (req_acc),
    .alu_sel_o   (alu_sel),
    .alu_op1_o   (alu_op1),
    .alu_op2_o   (alu_op2),
    .alu_res_i   (alu_res),
    .alu_zero_i  (alu_zero),
    .alu_neg_i   (alu_neg),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_res_o   (rsp_res),
    .rsp_zero_o  (rsp_zero),
    .rsp_neg_o   (rsp_neg),
    .op_count_o  (op_count)
  );

  // Presents a request while the DUT is idle; returns 1 ns after the accepting edge.
  task automatic send_req(input logic [1:0] sel, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic acc);
    req_valid = 1'b1;
    req_sel   = sel;
    req_op1   = a;
    req_op2   = b;
    req_acc   = acc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic pop_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_res !== 8'h00 || rsp_zero !== 1'b0 || rsp_neg !== 1'b0) begin
      errors++; $display("FAIL rst_rsp got=%h/%b/%b exp=00/0/0", rsp_res, rsp_zero, rsp_neg); end
    checks++; if (alu_sel !== OpAdd || alu_op1 !== 8'h00 || alu_op2 !== 8'h00) begin
      errors++; $display("FAIL rst_alu got=%b/%h/%h exp=00/00/00", alu_sel, alu_op1, alu_op2); end
    checks++; if (op_count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", op_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    send_req(OpAdd, 8'h05, 8'h03, 1'b0);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL add_exec got valid=%b ready=%b exp 0/0", rsp_valid, req_ready); end
    checks++; if (alu_sel !== OpAdd || alu_op1 !== 8'h05 || alu_op2 !== 8'h03) begin
      errors++; $display("FAIL add_alu got=%b/%h/%h exp=00/05/03", alu_sel, alu_op1, alu_op2); end
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL add_hold got valid=%b ready=%b exp 1/0", rsp_valid, req_ready); end
    checks++; if (rsp_res !== 8'h08 || rsp_zero !== 1'b0 || rsp_neg !== 1'b0) begin
      errors++; $display("FAIL add_rsp got=%h/%b/%b exp=08/0/0", rsp_res, rsp_zero, rsp_neg); end
    pop_rsp();
    checks++; if (op_count !== 4'd1) begin errors++; $display("FAIL add_count got=%0d exp=1", op_count); end
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_idle got ready=%b valid=%b exp 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_logic_ops();
    send_req(OpSub, 8'h03, 8'h05, 1'b0);
    @(posedge clk); #1;
    checks++; if (rsp_res !== 8'hFE || rsp_zero !== 1'b0 || rsp_neg !== 1'b1) begin
      errors++; $display("FAIL sub_rsp got=%h/%b/%b exp=fe/0/1", rsp_res, rsp_zero, rsp_neg); end
    pop_rsp();
    send_req(OpAnd, 8'hF0, 8'h0F, 1'b0);
    @(posedge clk); #1;
    checks++; if (rsp_res !== 8'h00 || rsp_zero !== 1'b1 || rsp_neg !== 1'b0) begin
      errors++; $display("FAIL and_rsp got=%h/%b/%b exp=00/1/0", rsp_res, rsp_zero, rsp_neg); end
    pop_rsp();
    send_req(OpOr, 8'hA0, 8'h05, 1'b0);
    @(posedge clk); #1;
    checks++; if (rsp_res !== 8'hA5 || rsp_zero !== 1'b0 || rsp_neg !== 1'b1) begin
      errors++; $display("FAIL or_rsp got=%h/%b/%b exp=a5/0/1", rsp_res, rsp_zero, rsp_neg); end
    pop_rsp();
    checks++; if (op_count !== 4'd4) begin errors++; $display("FAIL ops_count got=%0d exp=4", op_count); end
  endtask

  task automatic test_back_pressure();
    send_req(OpAdd, 8'h10, 8'h20, 1'b0);
    @(posedge clk); #1;
    // Keep a competing request asserted while the response is stalled.
    req_valid = 1'b1;
    req_sel   = OpSub;
    req_op1   = 8'h55;
    req_op2   = 8'h11;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hs[%0d] got valid=%b ready=%b exp 1/0", i, rsp_valid, req_ready); end
      checks++; if (rsp_res !== 8'h30 || rsp_zero !== 1'b0 || rsp_neg !== 1'b0) begin
        errors++; $display("FAIL bp_rsp[%0d] got=%h/%b/%b exp=30/0/0", i, rsp_res, rsp_zero, rsp_neg); end
      checks++; if (alu_sel !== OpAdd || alu_op1 !== 8'h10 || alu_op2 !== 8'h20) begin
        errors++; $display("FAIL bp_alu[%0d] got=%b/%h/%h exp=00/10/20", i, alu_sel, alu_op1, alu_op2); end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got ready=%b valid=%b exp 1/0", req_ready, rsp_valid); end
    checks++; if (op_count !== 4'd5) begin errors++; $display("FAIL bp_count got=%0d exp=5", op_count); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || alu_op1 !== 8'h10) begin
      errors++; $display("FAIL bp_no_dup got ready=%b op1=%h exp 1/10", req_ready, alu_op1); end
  endtask

  task automatic test_acc();
    send_req(OpAdd, 8'h7F, 8'h01, 1'b0);
    @(posedge clk); #1;
    checks++; if (rsp_res !== 8'h80 || rsp_neg !== 1'b1) begin
      errors++; $display("FAIL acc_first got=%h/%b exp=80/1", rsp_res, rsp_neg); end
    pop_rsp();
    send_req(OpAdd, 8'h01, 8'h01, 1'b1);
    @(posedge clk); #1;
`ifdef ALU_CTRL_ACC_EN
    checks++; if (rsp_res !== 8'h81 || rsp_neg !== 1'b1) begin
      errors++; $display("FAIL acc_second got=%h/%b exp=81/1", rsp_res, rsp_neg); end
`else
    checks++; if (rsp_res !== 8'h02 || rsp_neg !== 1'b0) begin
      errors++; $display("FAIL acc_second got=%h/%b exp=02/0", rsp_res, rsp_neg); end
`endif
    pop_rsp();
    checks++; if (op_count !== 4'd7) begin errors++; $display("FAIL acc_count got=%0d exp=7", op_count); end
  endtask

  task automatic test_reset_mid_op();
    send_req(OpAdd, 8'h01, 8'h02, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_state got ready=%b valid=%b exp 1/0", req_ready, rsp_valid); end
    checks++; if (op_count !== 4'd0) begin errors++; $display("FAIL rmid_count got=%0d exp=0", op_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_res !== 8'h00) begin
      errors++; $display("FAIL rmid_after got valid=%b ready=%b res=%h exp 0/1/00",
                         rsp_valid, req_ready, rsp_res); end
  endtask

  task automatic test_count_wrap();
    for (int i = 0; i < 16; i++) begin
      send_req(OpAdd, 8'(i), 8'h01, 1'b0);
      @(posedge clk); #1;
      pop_rsp();
      if (i == 14) begin
        checks++; if (op_count !== 4'd15) begin
          errors++; $display("FAIL wrap_pre got=%0d exp=15", op_count); end
      end
    end
    checks++; if (op_count !== 4'd0) begin errors++; $display("FAIL wrap_zero got=%0d exp=0", op_count); end
    checks++; if (rsp_res !== 8'h10) begin errors++; $display("FAIL wrap_res got=%h exp=10", rsp_res); end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_sel   = OpAdd;
    req_op1   = '0;
    req_op2   = '0;
    req_acc   = 1'b0;
    rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_logic_ops();
    test_back_pressure();
    test_acc();
    test_reset_mid_op();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
